// File: rtl/modacc.sv
// Modular accumulator: frames products from the modular multiplier and emits
// one sum mod MOD per frame, holding the result until downstream accepts it.
module modacc #(
    parameter int                MWIDTH = 39,
    parameter logic [MWIDTH-1:0] MOD    = 39'h40_0080_0001,
    parameter int                CWIDTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_acc_vld,
    input  logic [MWIDTH-1:0] i_acc_din,
    input  logic              i_acc_last,
    input  logic              i_acc_clr,
    input  logic              i_acc_rdy,
    output logic              o_acc_vld,
    output logic [MWIDTH-1:0] o_acc_dout,
    output logic [CWIDTH-1:0] o_acc_cnt,
    output logic              o_acc_ovf
);

    localparam logic [0:0]        IDLE    = 1'b0;
    localparam logic [0:0]        ACCUM   = 1'b1;
    localparam logic [CWIDTH-1:0] CNT_MAX = '1;

    logic [0:0]        state_reg, state_next;
    logic [MWIDTH-1:0] acc_reg, acc_next;
    logic [CWIDTH-1:0] cnt_reg, cnt_next;
    logic              vld_reg, vld_next;
    logic [MWIDTH-1:0] dout_reg, dout_next;
    logic              ovf_reg, ovf_next;

    logic [MWIDTH-1:0] acc_op;
    logic [MWIDTH:0]   sum;
    logic [MWIDTH:0]   diff;
    logic [MWIDTH-1:0] red;

    // A closed frame starts from zero regardless of what acc_reg holds.
    assign acc_op = (state_reg == ACCUM) ? acc_reg : '0;
    assign sum    = {1'b0, acc_op} + {1'b0, i_acc_din};
    assign diff   = sum - {1'b0, MOD};
    assign red    = (sum >= {1'b0, MOD}) ? diff[MWIDTH-1:0] : sum[MWIDTH-1:0];

    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        cnt_next   = cnt_reg;
        vld_next   = vld_reg;
        dout_next  = dout_reg;
        ovf_next   = ovf_reg;
        if (i_acc_clr) begin
            state_next = IDLE;
            acc_next   = '0;
            cnt_next   = '0;
            vld_next   = 1'b0;
            dout_next  = '0;
            ovf_next   = 1'b0;
        end else begin
            if (vld_reg && i_acc_rdy) begin
                vld_next  = 1'b0;
                dout_next = '0;
            end
            if (i_acc_vld) begin
                if (i_acc_last) begin
                    state_next = IDLE;
                    acc_next   = '0;
                    cnt_next   = '0;
                    // Result slot is free if empty or draining this cycle.
                    if (!vld_reg || i_acc_rdy) begin
                        vld_next  = 1'b1;
                        dout_next = red;
                    end else begin
                        ovf_next = 1'b1;
                    end
                end else begin
                    state_next = ACCUM;
                    acc_next   = red;
                    if (cnt_reg == CNT_MAX) begin
                        ovf_next = 1'b1;
                    end else begin
                        cnt_next = cnt_reg + CWIDTH'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            vld_reg   <= 1'b0;
            dout_reg  <= '0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            cnt_reg   <= cnt_next;
            vld_reg   <= vld_next;
            dout_reg  <= dout_next;
            ovf_reg   <= ovf_next;
        end
    end

    assign o_acc_vld  = vld_reg;
    assign o_acc_dout = dout_reg;
    assign o_acc_cnt  = cnt_reg;
    assign o_acc_ovf  = ovf_reg;

endmodule

// File: doc/modacc.md
MODACC -- requirements
Module: modacc

Purpose: downstream consumer of the pipelined modular multiplier output stream; frames multiplier products and accumulates them modulo MOD into one result per frame (dot-product / NTT inner-sum stage).

Interface
REQ-001 SHALL have parameter MOD, default 39'h40_0080_0001 (274886295553), modulus.
REQ-002 SHALL have parameter MWIDTH, default 39, data width; MOD < 2^MWIDTH.
REQ-003 SHALL have parameter CWIDTH, default 16, beat-counter width.
REQ-004 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port i_acc_vld  input  1  input beat valid (driven by multiplier vldout).
REQ-007 SHALL have port i_acc_din  input  MWIDTH  input beat data, contract din < MOD.
REQ-008 SHALL have port i_acc_last  input  1  qualifies final beat of frame; ignored when i_acc_vld=0.
REQ-009 SHALL have port i_acc_clr  input  1  synchronous flush.
REQ-010 SHALL have port i_acc_rdy  input  1  downstream ready for result.
REQ-011 SHALL have port o_acc_vld  output  1  result valid.
REQ-012 SHALL have port o_acc_dout  output  MWIDTH  frame sum mod MOD.
REQ-013 SHALL have port o_acc_cnt  output  CWIDTH  beats accumulated in the open frame.
REQ-014 SHALL have port o_acc_ovf  output  1  sticky error flag.

Function
REQ-015 SHALL accept a beat every cycle i_acc_vld=1; no input backpressure.
REQ-016 SHALL implement FSM IDLE (acc=0, cnt=0) and ACCUM (frame open); IDLE->ACCUM on non-last beat; ACCUM->IDLE on last beat; IDLE->IDLE on last beat (single-beat frame).
REQ-017 SHALL compute sum = acc + din on MWIDTH+1 bits, then red = sum>=MOD ? sum-MOD : sum; result exact for din<MOD.
REQ-018 SHALL on non-last beat load acc<=red, cnt<=cnt+1.
REQ-019 SHALL on last beat load output register with red, set o_acc_vld=1 next cycle (latency 1 from last beat), and clear acc and cnt to 0.
REQ-020 SHALL hold o_acc_vld and o_acc_dout stable until o_acc_vld & i_acc_rdy, then deassert o_acc_vld next cycle unless refilled.
REQ-021 SHALL allow drain and refill in same cycle: handshake completes and new result loaded, o_acc_vld stays 1.
REQ-022 SHALL, when last beat arrives while o_acc_vld=1 and i_acc_rdy=0, keep old result, drop new result, clear acc/cnt normally, set o_acc_ovf.
REQ-023 SHALL saturate cnt at 2^CWIDTH-1; a non-last beat at saturation still accumulates and sets o_acc_ovf.
REQ-024 SHALL give i_acc_clr priority over any same-cycle beat: beat discarded, acc, cnt, o_acc_vld, o_acc_ovf cleared, FSM to IDLE.
REQ-025 SHALL keep o_acc_ovf set until i_acc_clr or reset.
REQ-026 SHALL clear o_acc_dout to 0 when o_acc_vld deasserts.

Reset
REQ-027 SHALL on rst_n=0 asynchronously force FSM IDLE, acc=0, o_acc_cnt=0, o_acc_vld=0, o_acc_dout=0, o_acc_ovf=0.
REQ-028 SHALL ignore inputs while rst_n=0; reset mid-frame discards partial sum.

Verification
REQ-029 SHALL cover wrap: beats MOD-1, MOD-1, 2(last), rdy=1 -> one cycle after last o_acc_vld=1, o_acc_dout=0, o_acc_cnt back to 0.
REQ-030 SHALL cover single-beat frame: din=5 last=1 -> o_acc_dout=5 next cycle; cnt stays 0.
REQ-031 SHALL cover backpressure: frame {3,4 last}, rdy=0 for 5 cycles -> o_acc_dout=7 held, then one handshake; second frame {1 last} during stall -> ovf=1, dout still 7.
REQ-032 SHALL cover back-to-back: 1-beat frames 10,20,30 consecutive cycles, rdy=1 -> o_acc_dout 10,20,30 consecutive cycles, vld continuously 1.
REQ-033 SHALL cover clr with beat: frame {100, 200} then clr with vld=1 din=50 same cycle -> cnt=0, no output, next frame {9 last} -> dout=9.
REQ-034 SHALL cover reset mid-frame and CWIDTH=2 saturation: 4 non-last beats -> cnt=3, ovf=1; rst_n pulse -> all outputs 0.
